// File: rtl/riscv_biu_arbiter.sv
// riscv_biu_arbiter
//   Round-robin arbiter and sequencer that shares one AHB-Lite BIU between
//   PORTS requesters (I$, D$, ...). It registers a grant, drives the BIU
//   address request, counts data beats of the accepted burst, and at burst end
//   either releases the bus, re-grants a locked owner, or hands the bus to the
//   next round-robin requester. This block is control only: the datapath mux
//   uses gnt_idx_o in the address phase and data_idx_o in the data phase.
//
// Handshakes
//   - Requester p raises req_i[p] and holds it, with type_i/lock_i stable,
//     until it sees gnt_o[p] & biu_req_ack_i on the same rising edge.
//   - The BIU address phase completes on biu_req_o & biu_req_ack_i.
//   - Data beats complete on biu_ack_i in DATA. biu_err_i ends the burst at
//     once. biu_ack_i and biu_err_i are ignored outside DATA.
//
// Parameters
//   PORTS    number of requesters (>= 2)
//   TIMEOUT  watchdog limit in DATA cycles without a beat
//
// Ports
//   clk_i, rst_ni   clock (rising edge), asynchronous active-low reset
//   req_i           per-port request
//   type_i          per-port HBURST code, port p at type_i[3*p +: 3]
//   lock_i          per-port locked-sequence request
//   biu_req_ack_i   BIU accepted the address phase
//   biu_ack_i       BIU data beat acknowledge
//   biu_err_i       BIU data error, terminates the burst
//   biu_req_o       address-phase request to the BIU
//   gnt_o           one-hot address-phase grant
//   gnt_idx_o       address-phase port index
//   data_idx_o      data-phase owner index
//   busy_o          arbiter not idle
//   timeout_o       one-cycle watchdog pulse
//
// Configuration
//   RISCV_ARB_WDOG_EN  when defined, a watchdog aborts a DATA phase that sees
//                      no beat for TIMEOUT cycles. When undefined there is no
//                      counter, timeout_o is tied low and DATA waits forever.

module riscv_biu_arbiter #(
  parameter int PORTS   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [PORTS-1:0]         req_i,
  input  logic [3*PORTS-1:0]       type_i,
  input  logic [PORTS-1:0]         lock_i,
  input  logic                     biu_req_ack_i,
  input  logic                     biu_ack_i,
  input  logic                     biu_err_i,
  output logic                     biu_req_o,
  output logic [PORTS-1:0]         gnt_o,
  output logic [$clog2(PORTS)-1:0] gnt_idx_o,
  output logic [$clog2(PORTS)-1:0] data_idx_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int IW = $clog2(PORTS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]   data_idx_q, data_idx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]      beat_cnt_q, beat_cnt_d;
  logic            burst_end;
  logic            wdog_fire;

  // First requester found scanning base+1, base+2, ... modulo PORTS.
  function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] base,
                                            input logic [PORTS-1:0] req);
    logic [IW-1:0] winner;
    logic          found;
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= PORTS; i++) begin
      int idx;
      idx = (int'(base) + i) % PORTS;
      if (!found && req[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
    return winner;
  endfunction

  // Beats minus one. Each HBURST pair (WRAPn/INCRn) shares a length, so only
  // the upper two bits matter.
  function automatic logic [3:0] burst_len(input logic [2:0] hburst);
    logic [3:0] len;
    case (hburst[2:1])
      2'd0:    len = 4'd0;
      2'd1:    len = 4'd3;
      2'd2:    len = 4'd7;
      default: len = 4'd15;
    endcase
    return len;
  endfunction

`ifdef RISCV_ARB_WDOG_EN
  localparam int WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WDW-1:0] wd_q;

  // Cleared on DATA entry and on every beat, counts idle DATA cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else if (state_q == ST_ADDR && biu_req_ack_i) begin
      wd_q <= '0;
    end else if (state_q == ST_DATA) begin
      if (biu_ack_i || biu_err_i) wd_q <= '0;
      else                        wd_q <= wd_q + WDW'(1);
    end
  end

  assign wdog_fire = (state_q == ST_DATA) && !biu_ack_i && !biu_err_i &&
                     (wd_q == WDW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wdog_fire      = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= '0;
      data_idx_q <= '0;
      rr_ptr_q   <= IW'(PORTS - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      data_idx_q <= data_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    data_idx_d = data_idx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    burst_end  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          gnt_idx_d = rr_pick(rr_ptr_q, req_i);
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // Grant stays frozen until the BIU takes the address phase.
        if (biu_req_ack_i) begin
          beat_cnt_d = burst_len(type_i[int'(gnt_idx_q)*3 +: 3]);
          data_idx_d = gnt_idx_q;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (biu_err_i || wdog_fire || (biu_ack_i && beat_cnt_q == 4'd0)) begin
          burst_end = 1'b1;
        end else if (biu_ack_i) begin
          beat_cnt_d = beat_cnt_q - 4'd1;
        end
        // Burst end is resolved in the same cycle as the last beat, so the
        // next address phase starts on the following cycle.
        if (burst_end) begin
          if (lock_i[data_idx_q] && req_i[data_idx_q] && !wdog_fire) begin
            gnt_idx_d = data_idx_q;
            state_d   = ST_ADDR;
          end else begin
            rr_ptr_d = data_idx_q;
            if (|req_i) begin
              gnt_idx_d = rr_pick(data_idx_q, req_i);
              state_d   = ST_ADDR;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o = '0;
    if (state_q == ST_ADDR) gnt_o[gnt_idx_q] = 1'b1;
  end

  assign biu_req_o  = (state_q == ST_ADDR);
  assign busy_o     = (state_q != ST_IDLE);
  assign gnt_idx_o  = gnt_idx_q;
  assign data_idx_o = data_idx_q;
  assign timeout_o  = wdog_fire;

endmodule

// File: tb/tb_riscv_biu_arbiter.sv
// Testbench for riscv_biu_arbiter (2 ports, TIMEOUT=16).
// Inputs are driven at the falling edge, outputs sampled at the falling edge.
module tb_riscv_biu_arbiter;

  localparam int P   = 2;
  localparam int IW  = $clog2(P);
  localparam int TMO = 16;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [P-1:0]   req_i;
  logic [3*P-1:0] type_i;
  logic [P-1:0]   lock_i;
  logic           biu_req_ack_i;
  logic           biu_ack_i;
  logic           biu_err_i;
  logic           biu_req_o;
  logic [P-1:0]   gnt_o;
  logic [IW-1:0]  gnt_idx_o;
  logic [IW-1:0]  data_idx_o;
  logic           busy_o;
  logic           timeout_o;

  int checks   = 0;
  int failures = 0;

  riscv_biu_arbiter #(.PORTS(P), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .type_i(type_i),
    .lock_i(lock_i), .biu_req_ack_i(biu_req_ack_i), .biu_ack_i(biu_ack_i),
    .biu_err_i(biu_err_i), .biu_req_o(biu_req_o), .gnt_o(gnt_o),
    .gnt_idx_o(gnt_idx_o), .data_idx_o(data_idx_o), .busy_o(busy_o),
    .timeout_o(timeout_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    req_i = '0; type_i = '0; lock_i = '0;
    biu_req_ack_i = 1'b0; biu_ack_i = 1'b0; biu_err_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_type(input int p, input int t);
    type_i[p*3 +: 3] = 3'(t);
  endtask

  task automatic wait_addr(output int waited);
    waited = 0;
    while (biu_req_o !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
  endtask

  task automatic accept_addr();
    biu_req_ack_i = 1'b1;
    step();
    biu_req_ack_i = 1'b0;
  endtask

  task automatic beat(input logic a, input logic e);
    biu_ack_i = a;
    biu_err_i = e;
    step();
    biu_ack_i = 1'b0;
    biu_err_i = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic int model_pick(input int ptr, input logic [P-1:0] req);
    for (int k = 1; k <= P; k++)
      if (req[(ptr + k) % P]) return (ptr + k) % P;
    return -1;
  endfunction

  function automatic int model_beats(input int t);
    if (t < 2) return 1;
    return 2 << (t >> 1);
  endfunction

  function automatic logic [P-1:0] onehot(input int p);
    logic [P-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // A granted requester must keep its request until the address is taken.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && biu_req_o === 1'b1 && req_i[gnt_idx_o] !== 1'b1) begin
      failures++;
      $display("FAIL req_hold port=%0d req=%b", gnt_idx_o, req_i);
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    step();
    checks++; if (biu_req_o !== 1'b0) begin failures++; $display("FAIL reset_biu_req got=%b exp=0", biu_req_o); end
    checks++; if (gnt_o !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt_o); end
    checks++; if (gnt_idx_o !== '0) begin failures++; $display("FAIL reset_gnt_idx got=%0d exp=0", gnt_idx_o); end
    checks++; if (data_idx_o !== '0) begin failures++; $display("FAIL reset_data_idx got=%0d exp=0", data_idx_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
    rst_ni = 1'b1;
    step();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_reset_mid_burst();
    int w;
    do_reset();
    req_i = 2'b01;
    wait_addr(w);
    accept_addr();
    req_i = 2'b00;
    beat(1'b1, 1'b0);
    set_type(1, 5);
    req_i = 2'b10;
    wait_addr(w);
    checks++; if (gnt_idx_o !== 1'b1) begin failures++; $display("FAIL rmb_grant got=%0d exp=1", gnt_idx_o); end
    accept_addr();
    req_i = 2'b00;
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    checks++; if (busy_o !== 1'b1 || data_idx_o !== 1'b1) begin failures++; $display("FAIL rmb_in_data busy=%b data_idx=%0d exp busy=1 idx=1", busy_o, data_idx_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rmb_busy got=%b exp=0", busy_o); end
    checks++; if (data_idx_o !== '0) begin failures++; $display("FAIL rmb_data_idx got=%0d exp=0", data_idx_o); end
    checks++; if (gnt_idx_o !== '0 || gnt_o !== '0 || biu_req_o !== 1'b0 || timeout_o !== 1'b0) begin
      failures++; $display("FAIL rmb_outputs gnt_idx=%0d gnt=%b biu_req=%b timeout=%b exp all 0", gnt_idx_o, gnt_o, biu_req_o, timeout_o); end
    clear_inputs();
    step();
    rst_ni = 1'b1;
    step();
    req_i = 2'b11;
    wait_addr(w);
    checks++; if (gnt_idx_o !== 1'b0 || w !== 1) begin failures++; $display("FAIL rmb_first_grant got=%0d wait=%0d exp port 0 wait 1", gnt_idx_o, w); end
  endtask

  task automatic test_round_robin();
    int w, ptr, exp;
    do_reset();
    req_i = 2'b11;
    ptr = P - 1;
    for (int k = 0; k < 4; k++) begin
      exp = model_pick(ptr, req_i);
      wait_addr(w);
      checks++; if (w !== ((k == 0) ? 1 : 0)) begin failures++; $display("FAIL rr_latency k=%0d got=%0d exp=%0d", k, w, (k == 0) ? 1 : 0); end
      checks++; if (gnt_idx_o !== IW'(exp) || gnt_o !== onehot(exp) || biu_req_o !== 1'b1) begin
        failures++; $display("FAIL rr_grant k=%0d idx=%0d gnt=%b req=%b exp idx=%0d", k, gnt_idx_o, gnt_o, biu_req_o, exp); end
      accept_addr();
      checks++; if (data_idx_o !== IW'(exp) || biu_req_o !== 1'b0 || gnt_o !== '0) begin
        failures++; $display("FAIL rr_data k=%0d data_idx=%0d req=%b gnt=%b exp idx=%0d", k, data_idx_o, biu_req_o, gnt_o, exp); end
      if (k == 3) req_i = 2'b00;
      beat(1'b1, 1'b0);
      ptr = exp;
    end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rr_idle got=%b exp=0", busy_o); end
  endtask

  task automatic test_incr4();
    int w;
    do_reset();
    set_type(0, 3);
    req_i = 2'b01;
    wait_addr(w);
    accept_addr();
    req_i = 2'b00;
    for (int b = 0; b < 4; b++) begin
      checks++; if (busy_o !== 1'b1 || biu_req_o !== 1'b0) begin failures++; $display("FAIL incr4_beat b=%0d busy=%b req=%b exp busy=1 req=0", b, busy_o, biu_req_o); end
      beat(1'b1, 1'b0);
    end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL incr4_end got=%b exp=0", busy_o); end
    beat(1'b1, 1'b0);
    checks++; if (busy_o !== 1'b0 || biu_req_o !== 1'b0 || gnt_o !== '0) begin
      failures++; $display("FAIL incr4_extra_ack busy=%b req=%b gnt=%b exp 0", busy_o, biu_req_o, gnt_o); end
  endtask

  task automatic test_err();
    int w;
    do_reset();
    set_type(1, 4);
    req_i = 2'b10;
    wait_addr(w);
    checks++; if (gnt_idx_o !== 1'b1) begin failures++; $display("FAIL err_grant got=%0d exp=1", gnt_idx_o); end
    accept_addr();
    req_i = 2'b01;
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    checks++; if (busy_o !== 1'b1 || biu_req_o !== 1'b0) begin failures++; $display("FAIL err_mid busy=%b req=%b exp busy=1 req=0", busy_o, biu_req_o); end
    beat(1'b1, 1'b1);
    checks++; if (biu_req_o !== 1'b1 || gnt_idx_o !== 1'b0 || gnt_o !== 2'b01) begin
      failures++; $display("FAIL err_next req=%b idx=%0d gnt=%b exp req=1 idx=0 gnt=01", biu_req_o, gnt_idx_o, gnt_o); end
    accept_addr();
    req_i = 2'b00;
    checks++; if (data_idx_o !== 1'b0) begin failures++; $display("FAIL err_data_idx got=%0d exp=0", data_idx_o); end
    beat(1'b1, 1'b0);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL err_idle got=%b exp=0", busy_o); end
  endtask

  task automatic test_lock();
    int w;
    int exp_seq[4] = '{0, 0, 0, 1};
    do_reset();
    req_i = 2'b11;
    lock_i = 2'b01;
    for (int k = 0; k < 4; k++) begin
      wait_addr(w);
      checks++; if (gnt_idx_o !== IW'(exp_seq[k]) || w !== ((k == 0) ? 1 : 0)) begin
        failures++; $display("FAIL lock_grant k=%0d got=%0d wait=%0d exp=%0d", k, gnt_idx_o, w, exp_seq[k]); end
      accept_addr();
      if (k == 2) lock_i = 2'b00;
      if (k == 3) req_i = 2'b00;
      beat(1'b1, 1'b0);
    end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL lock_idle got=%b exp=0", busy_o); end
  endtask

  task automatic test_random();
    int pend[P];
    int cur_t[P];
    int m_ptr, exp_owner, owner, beats, err_at, w, exp_wait, nstall;
    logic e;
    do_reset();
    m_ptr = P - 1;
    exp_owner = -1;
    for (int p = 0; p < P; p++) begin pend[p] = 0; cur_t[p] = 0; end
    for (int t = 0; t < 50; t++) begin
      exp_wait = 0;
      if (exp_owner < 0) begin
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rnd_idle t=%0d busy=%b exp=0", t, busy_o); end
        beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checks++; if (busy_o !== 1'b0 || biu_req_o !== 1'b0) begin failures++; $display("FAIL rnd_stray t=%0d busy=%b req=%b exp 0", t, busy_o, biu_req_o); end
        for (int p = 0; p < P; p++) pend[p] = $urandom_range(0, 3);
        if (pend[0] == 0 && pend[1] == 0) pend[$urandom_range(0, P-1)] = 1;
        for (int p = 0; p < P; p++) begin
          cur_t[p] = $urandom_range(0, 7);
          set_type(p, cur_t[p]);
          req_i[p] = (pend[p] > 0);
          lock_i[p] = ($urandom_range(0, 2) == 0);
        end
        exp_owner = model_pick(m_ptr, req_i);
        exp_wait = 1;
      end
      wait_addr(w);
      checks++; if (w !== exp_wait) begin failures++; $display("FAIL rnd_wait t=%0d got=%0d exp=%0d", t, w, exp_wait); end
      if (w >= 40) return;
      owner = exp_owner;
      checks++; if (gnt_idx_o !== IW'(owner) || gnt_o !== onehot(owner)) begin
        failures++; $display("FAIL rnd_grant t=%0d idx=%0d gnt=%b exp=%0d", t, gnt_idx_o, gnt_o, owner); end
      beats = model_beats(cur_t[owner]);
      err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, beats - 1) : -1;
      accept_addr();
      pend[owner]--;
      if (pend[owner] > 0) begin cur_t[owner] = $urandom_range(0, 7); set_type(owner, cur_t[owner]); end
      req_i[owner] = (pend[owner] > 0);
      for (int p = 0; p < P; p++) lock_i[p] = ($urandom_range(0, 2) == 0);
      checks++; if (data_idx_o !== IW'(owner) || busy_o !== 1'b1 || biu_req_o !== 1'b0) begin
        failures++; $display("FAIL rnd_data t=%0d data_idx=%0d busy=%b req=%b exp idx=%0d", t, data_idx_o, busy_o, biu_req_o, owner); end
      for (int b = 0; b < beats; b++) begin
        nstall = $urandom_range(0, 2);
        for (int s = 0; s < nstall; s++) step();
        for (int p = 0; p < P; p++) begin
          if (pend[p] == 0 && $urandom_range(0, 7) == 0) begin
            pend[p] = $urandom_range(1, 3);
            cur_t[p] = $urandom_range(0, 7);
            set_type(p, cur_t[p]);
            req_i[p] = 1'b1;
          end
        end
        e = (b == err_at);
        beat(e ? 1'($urandom_range(0, 1)) : 1'b1, e);
        if (e) break;
      end
      if (lock_i[owner] && req_i[owner]) begin
        exp_owner = owner;
      end else begin
        m_ptr = owner;
        exp_owner = model_pick(m_ptr, req_i);
      end
      checks++;
      if (exp_owner < 0) begin
        if (busy_o !== 1'b0) begin failures++; $display("FAIL rnd_end_idle t=%0d busy=%b exp=0", t, busy_o); end
      end else if (biu_req_o !== 1'b1 || gnt_idx_o !== IW'(exp_owner)) begin
        failures++; $display("FAIL rnd_end_addr t=%0d req=%b idx=%0d exp req=1 idx=%0d", t, biu_req_o, gnt_idx_o, exp_owner);
      end
      checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL rnd_timeout t=%0d got=%b exp=0", t, timeout_o); end
    end
  endtask

`ifdef RISCV_ARB_WDOG_EN
  task automatic test_watchdog();
    int w, n;
    do_reset();
    req_i = 2'b01;
    wait_addr(w);
    accept_addr();
    req_i = 2'b00;
    n = 0;
    while (timeout_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++; if (n !== TMO - 1) begin failures++; $display("FAIL wdog_delay got=%0d exp=%0d", n, TMO - 1); end
    step();
    checks++; if (timeout_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL wdog_after timeout=%b busy=%b exp 0", timeout_o, busy_o); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    test_reset();
    test_reset_mid_burst();
    test_round_robin();
    test_incr4();
    test_err();
    test_lock();
    test_random();
`ifdef RISCV_ARB_WDOG_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL global_time_limit reached at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
